sensor_hub_ctrl: RTL
====================

SENSOR_HUB_CTRL -- requirements
Module: sensor_hub_ctrl

Interface
REQ-001 The block SHALL have parameter N_CH, default 8, giving the number of sensor channels (legal 1..32).
REQ-002 The block SHALL have parameter BYTE_TIMEOUT_CYC, default 50_000_000, giving the cycles allowed between command byte and address byte.
REQ-003 The block SHALL have parameter SENSOR_TIMEOUT_CYC, default 150_000_000, giving the cycles allowed from sensor request to sensor done.
REQ-004 The block SHALL have parameter POLL_PERIOD_CYC, default 100_000_000, giving the continuous-mode re-read interval.
REQ-005 The block SHALL have port clock_50Mhz, input, 1 bit: the single system clock.
REQ-006 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port rx_valid, input, 1 bit: one-cycle pulse marking that rx_byte is valid.
REQ-008 The block SHALL have port rx_byte, input, 8 bits: the received UART byte.
REQ-009 The block SHALL have port tx_busy, input, 1 bit: high while the UART transmitter is sending.
REQ-010 The block SHALL have port tx_start, output, 1 bit: one-cycle pulse that launches tx_byte.
REQ-011 The block SHALL have port tx_byte, output, 8 bits: the byte to transmit.
REQ-012 The block SHALL have port sensor_enable, output, N_CH bits: one-hot request pulse, one cycle wide.
REQ-013 The block SHALL have port sensor_done, input, N_CH bits: per-channel completion pulse.
REQ-014 The block SHALL have port sensor_error, input, N_CH bits: per-channel fault flag, valid together with done.
REQ-015 The block SHALL have port sensor_data, input, 40*N_CH bits: per channel, the bytes hum_int, hum_dec, temp_int, temp_dec, checksum, MSB first.

Function
REQ-016 The packet format SHALL be: command byte first, then address byte; the response SHALL be 2 bytes, code then value.
REQ-017 The FSM states SHALL be IDLE, GET_ADDR, DECODE, REQ, WAIT, BUILD, SEND0, WAIT0, SEND1, WAIT1.
REQ-018 In IDLE, an rx_valid pulse SHALL latch the command byte and move the FSM to GET_ADDR.
REQ-019 In GET_ADDR, an rx_valid pulse SHALL latch the address and move to DECODE; reaching BYTE_TIMEOUT_CYC first SHALL discard the command and return to IDLE with no response.
REQ-020 DECODE SHALL take one cycle and SHALL check the address: address >= N_CH SHALL give response {0xFE, addr}.
REQ-021 DECODE SHALL check the command against the set 0x00 status, 0x01 humidity, 0x02 temperature, 0x03 continuous temperature, 0x04 continuous humidity, 0x05 stop continuous; any other command SHALL give response {0xFF, cmd}.
REQ-022 An address error SHALL take priority over a command error.
REQ-023 For commands 0x00..0x04, REQ SHALL raise sensor_enable[addr] for exactly one cycle, then the FSM SHALL enter WAIT.
REQ-024 WAIT SHALL exit on sensor_done[addr], or on reaching SENSOR_TIMEOUT_CYC; a timeout SHALL give {0x1F, 0x00}.
REQ-025 Checksum rule: a read SHALL fail if byte4 != (byte0+byte1+byte2+byte3) mod 256, or if sensor_error[addr] is set; a failed read SHALL give {0x1F, 0x00}.
REQ-026 On a good read, the responses SHALL be: 0x00 -> {0x07, 0x00}; 0x01 and 0x04 -> {0x08, hum_int}; 0x02 and 0x03 -> {0x09, temp_int}.
REQ-027 Commands 0x03/0x04 SHALL set the continuous register {active, chan, kind}.
REQ-028 Command 0x05 SHALL clear the continuous register and respond {0x0A, addr} without a sensor access.
REQ-029 A sensor error or timeout in continuous mode SHALL clear the continuous register.
REQ-030 The poll timer SHALL run only while continuous mode is active.
REQ-031 When the poll timer expires in IDLE, the block SHALL re-run REQ/WAIT/BUILD on the stored channel.
REQ-032 When the poll timer expires outside IDLE, the poll SHALL be held pending until IDLE.
REQ-033 If rx_valid and a poll expiry coincide in IDLE, the host command SHALL win and the poll SHALL stay pending.
REQ-034 Transmit handshake: SEND0 SHALL wait for tx_busy low, then pulse tx_start with the code byte; WAIT0 SHALL wait for tx_busy to rise and then fall; SEND1/WAIT1 SHALL do the same for the value byte; the FSM SHALL then return to IDLE.
REQ-035 rx_valid outside IDLE/GET_ADDR SHALL be ignored; the dropped bytes SHALL not be buffered.
REQ-036 Response latency SHALL be: the first tx_start no later than 3 cycles after done when tx_busy is low, and 3 cycles after the address byte for error responses.

Reset
REQ-037 While reset_n is low, the FSM SHALL be in IDLE; tx_start, sensor_enable, tx_byte, the latched command and address, all counters, the pending-poll flag and the continuous register SHALL be 0.
REQ-038 Reset asserted mid-transfer SHALL abort immediately with no further tx_start pulse.
REQ-039 After release, the block SHALL accept a new command on the first rx_valid.

Structure
REQ-040 The command codes, response codes, state encoding and packet byte count SHALL live in a shared package sensor_hub_pkg.
REQ-041 The timeout/poll counter SHALL be one reusable sub-module cycle_timer (parameter width, with load, enable and expired ports), instantiated twice: timeout and poll.
REQ-042 Channel selection SHALL be by an indexed part-select of sensor_data; no per-channel storage SHALL be used.

Verification
REQ-043 Cmd 0x02, addr 0x03, with ch3 data {45,0,27,0,72} -> sensor_enable=0x08 for one cycle, then tx bytes 0x09 then 0x1B.
REQ-044 Cmd 0x01, addr 0x03, with checksum byte 0x00 (bad) -> response 0x1F, 0x00.
REQ-045 Cmd 0x02, addr 0x09, with N_CH=8 -> response 0xFE, 0x09, with no sensor_enable pulse; cmd 0x42, addr 0x09 -> 0xFE, 0x09 (address error takes priority).
REQ-046 Cmd 0x03 on addr 0x00, with POLL_PERIOD_CYC=1000 -> unsolicited 0x09 responses every >=1000 cycles; then cmd 0x05 -> 0x0A, 0x00, and no further polls.
REQ-047 Cmd byte, then no address for BYTE_TIMEOUT_CYC -> no tx_start; a subsequent full packet is handled normally; sensor_done never arrives -> 0x1F, 0x00 after SENSOR_TIMEOUT_CYC.
REQ-048 reset_n low between tx bytes 1 and 2 -> no second tx_start, all outputs 0, continuous mode cleared.

Source files
------------

// File: rtl/sensor_hub_pkg.sv
// sensor_hub_pkg
//   Shared definitions for the sensor hub controller: the FSM state
//   encoding, host command codes, response codes, the response packet
//   length, the timer width and the sensor frame checksum helper.
package sensor_hub_pkg;

  typedef enum logic [3:0] {
    IDLE,
    GET_ADDR,
    DECODE,
    REQ,
    WAIT,
    BUILD,
    SEND0,
    WAIT0,
    SEND1,
    WAIT1
  } state_t;

  // Host command codes (first byte of a request packet)
  localparam logic [7:0] CMD_STATUS    = 8'h00;
  localparam logic [7:0] CMD_HUM       = 8'h01;
  localparam logic [7:0] CMD_TEMP      = 8'h02;
  localparam logic [7:0] CMD_CONT_TEMP = 8'h03;
  localparam logic [7:0] CMD_CONT_HUM  = 8'h04;
  localparam logic [7:0] CMD_STOP      = 8'h05;

  // Response codes (first byte of a response packet)
  localparam logic [7:0] RSP_STATUS     = 8'h07;
  localparam logic [7:0] RSP_HUM        = 8'h08;
  localparam logic [7:0] RSP_TEMP       = 8'h09;
  localparam logic [7:0] RSP_STOP       = 8'h0A;
  localparam logic [7:0] RSP_SENSOR_ERR = 8'h1F;
  localparam logic [7:0] RSP_ADDR_ERR   = 8'hFE;
  localparam logic [7:0] RSP_CMD_ERR    = 8'hFF;

  // Every response is code byte followed by value byte
  localparam int PKT_BYTES = 2;

  // Wide enough for the largest default timeout (150M cycles)
  localparam int TIMER_W = 32;

  // A sensor frame is {hum_int, hum_dec, temp_int, temp_dec, checksum};
  // the checksum is the 8-bit wrapping sum of the four data bytes.
  function automatic logic checksum_ok(input logic [39:0] frame);
    logic [7:0] sum;
    sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    return sum == frame[7:0];
  endfunction

endpackage

// File: rtl/sensor_hub_ctrl_timer.sv
// cycle_timer
//   Generic saturating cycle counter. It counts enabled cycles since the
//   last load and flags expiry once the count reaches limit.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     load       : restart the count from zero on the next edge
//     enable     : count this cycle
//     limit      : number of enabled cycles until expiry
//     expired    : high while enabled and the count has reached limit
module cycle_timer
  import sensor_hub_pkg::*;
#(
  parameter int WIDTH = TIMER_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Count saturates at limit so a stalled consumer still sees expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable && (count < limit)) begin
      count <= count + 1'b1;
    end
  end

  // Expiry must not depend on load: callers reload on expiry
  assign expired = enable && (count >= limit);

endmodule

// File: rtl/sensor_hub_ctrl.sv
// sensor_hub_ctrl
//   Two-byte UART command interpreter for a bank of humidity/temperature
//   sensors. A request is {command, address}; the answer is {code, value}.
//   Supports one-shot reads and a continuous mode that re-reads a stored
//   channel every POLL_PERIOD_CYC cycles.
//   Ports:
//     clock_50Mhz, reset_n     : system clock, asynchronous active-low reset
//     rx_valid, rx_byte        : received UART byte strobe and data
//     tx_busy                  : UART transmitter busy
//     tx_start, tx_byte        : one-cycle launch pulse and byte to send
//     sensor_enable            : one-hot one-cycle read request
//     sensor_done/sensor_error : per-channel completion pulse and fault flag
//     sensor_data              : 40 bits per channel, channel 0 in the LSBs
module sensor_hub_ctrl
  import sensor_hub_pkg::*;
#(
  parameter int N_CH               = 8,
  parameter int BYTE_TIMEOUT_CYC   = 50_000_000,
  parameter int SENSOR_TIMEOUT_CYC = 150_000_000,
  parameter int POLL_PERIOD_CYC    = 100_000_000
) (
  input  logic                 clock_50Mhz,
  input  logic                 reset_n,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_byte,
  input  logic                 tx_busy,
  output logic                 tx_start,
  output logic [7:0]           tx_byte,
  output logic [N_CH-1:0]      sensor_enable,
  input  logic [N_CH-1:0]      sensor_done,
  input  logic [N_CH-1:0]      sensor_error,
  input  logic [40*N_CH-1:0]   sensor_data
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [N_CH-1:0] CH0_MASK = N_CH'(1);

  state_t            state;
  logic [7:0]        cmd;
  logic [7:0]        addr;
  logic [7:0]        resp_code;
  logic [7:0]        resp_val;
  logic              read_fail;
  logic              saw_busy;
  logic              cont_active;
  logic              cont_kind;
  logic [CH_W-1:0]   cont_chan;
  logic              poll_pending;

  logic              addr_ok;
  logic [CH_W-1:0]   ch_idx;
  logic [N_CH-1:0]   ch_mask;
  logic [39:0]       ch_data;
  logic              ch_done;
  logic              ch_error;

  logic              to_enable;
  logic              to_expired;
  logic [TIMER_W-1:0] to_limit;
  logic              poll_load;
  logic              poll_expired;

  // Channel select; out-of-range addresses never reach a sensor access,
  // so they are folded onto channel 0 to keep the part-select in range.
  assign addr_ok  = int'(addr) < N_CH;
  assign ch_idx   = addr_ok ? addr[CH_W-1:0] : '0;
  assign ch_mask  = CH0_MASK << ch_idx;
  assign ch_data  = sensor_data[40*int'(ch_idx) +: 40];
  assign ch_done  = |(sensor_done & ch_mask);
  assign ch_error = |(sensor_error & ch_mask);

  // One timer serves both the inter-byte and the sensor timeouts; it is
  // held cleared in every other state so each wait starts from zero.
  assign to_enable = (state == GET_ADDR) || (state == WAIT);
  assign to_limit  = (state == WAIT) ? TIMER_W'(SENSOR_TIMEOUT_CYC)
                                     : TIMER_W'(BYTE_TIMEOUT_CYC);

  cycle_timer #(.WIDTH(TIMER_W)) u_timeout (
    .clk     (clock_50Mhz),
    .rst_n   (reset_n),
    .load    (!to_enable),
    .enable  (to_enable),
    .limit   (to_limit),
    .expired (to_expired)
  );

  // Poll timer free-runs while continuous mode is active, restarting
  // itself on each expiry.
  assign poll_load = !cont_active || poll_expired;

  cycle_timer #(.WIDTH(TIMER_W)) u_poll (
    .clk     (clock_50Mhz),
    .rst_n   (reset_n),
    .load    (poll_load),
    .enable  (cont_active),
    .limit   (TIMER_W'(POLL_PERIOD_CYC)),
    .expired (poll_expired)
  );

  // Main controller: packet capture, decode, sensor access, response
  // build and the two-byte transmit handshake. A poll is replayed as if
  // the stored continuous command had arrived from the host.
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cmd           <= '0;
      addr          <= '0;
      resp_code     <= '0;
      resp_val      <= '0;
      read_fail     <= 1'b0;
      saw_busy      <= 1'b0;
      cont_active   <= 1'b0;
      cont_kind     <= 1'b0;
      cont_chan     <= '0;
      poll_pending  <= 1'b0;
      tx_start      <= 1'b0;
      tx_byte       <= '0;
      sensor_enable <= '0;
    end else begin
      tx_start      <= 1'b0;
      sensor_enable <= '0;
      if (poll_expired) poll_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (rx_valid) begin
            cmd   <= rx_byte;
            state <= GET_ADDR;
          end else if (cont_active && (poll_pending || poll_expired)) begin
            poll_pending <= 1'b0;
            cmd   <= cont_kind ? CMD_CONT_HUM : CMD_CONT_TEMP;
            addr  <= 8'(cont_chan);
            state <= REQ;
          end
        end

        GET_ADDR: begin
          if (rx_valid) begin
            addr  <= rx_byte;
            state <= DECODE;
          end else if (to_expired) begin
            state <= IDLE;
          end
        end

        DECODE: begin
          if (!addr_ok) begin
            resp_code <= RSP_ADDR_ERR;
            resp_val  <= addr;
            state     <= SEND0;
          end else begin
            case (cmd)
              CMD_STATUS, CMD_HUM, CMD_TEMP: state <= REQ;
              CMD_CONT_TEMP, CMD_CONT_HUM: begin
                cont_active <= 1'b1;
                cont_chan   <= addr[CH_W-1:0];
                cont_kind   <= (cmd == CMD_CONT_HUM);
                state       <= REQ;
              end
              CMD_STOP: begin
                cont_active  <= 1'b0;
                cont_chan    <= '0;
                cont_kind    <= 1'b0;
                poll_pending <= 1'b0;
                resp_code    <= RSP_STOP;
                resp_val     <= addr;
                state        <= SEND0;
              end
              default: begin
                resp_code <= RSP_CMD_ERR;
                resp_val  <= cmd;
                state     <= SEND0;
              end
            endcase
          end
        end

        REQ: begin
          sensor_enable <= ch_mask;
          state         <= WAIT;
        end

        // sensor_error is only valid alongside done, so judge it here
        WAIT: begin
          if (ch_done) begin
            read_fail <= ch_error || !checksum_ok(ch_data);
            state     <= BUILD;
          end else if (to_expired) begin
            read_fail <= 1'b1;
            state     <= BUILD;
          end
        end

        BUILD: begin
          if (read_fail) begin
            resp_code <= RSP_SENSOR_ERR;
            resp_val  <= 8'h00;
            if ((cmd == CMD_CONT_TEMP) || (cmd == CMD_CONT_HUM)) begin
              cont_active  <= 1'b0;
              cont_chan    <= '0;
              cont_kind    <= 1'b0;
              poll_pending <= 1'b0;
            end
          end else begin
            case (cmd)
              CMD_STATUS: begin
                resp_code <= RSP_STATUS;
                resp_val  <= 8'h00;
              end
              CMD_HUM, CMD_CONT_HUM: begin
                resp_code <= RSP_HUM;
                resp_val  <= ch_data[39:32];
              end
              default: begin
                resp_code <= RSP_TEMP;
                resp_val  <= ch_data[23:16];
              end
            endcase
          end
          state <= SEND0;
        end

        SEND0: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_byte  <= resp_code;
            saw_busy <= 1'b0;
            state    <= WAIT0;
          end
        end

        // Wait for the transmitter to take the byte and then finish it
        WAIT0: begin
          if (tx_busy) saw_busy <= 1'b1;
          else if (saw_busy) state <= SEND1;
        end

        SEND1: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_byte  <= resp_val;
            saw_busy <= 1'b0;
            state    <= WAIT1;
          end
        end

        WAIT1: begin
          if (tx_busy) saw_busy <= 1'b1;
          else if (saw_busy) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
